// File: rtl/spi_quad_raster_if.sv
// SPI bus bundle for the quad rasterizer.
// The master drives sclk/mosi/cs and the slave drives miso.
interface spi_quad_raster_if;
  logic io_spi_mosi;
  logic io_spi_miso;
  logic io_spi_sclk;
  logic io_spi_cs;

  modport master (
    output io_spi_mosi,
    output io_spi_sclk,
    output io_spi_cs,
    input  io_spi_miso
  );

  modport slave (
    input  io_spi_mosi,
    input  io_spi_sclk,
    input  io_spi_cs,
    output io_spi_miso
  );
endinterface

// File: rtl/spi_quad_raster.sv
// SPI-fed quad outline rasterizer (Bresenham, one pixel per clock).
// Define SPI_QUAD_PIXEL_PORT_EN to expose the pixel stream.
module spi_quad_raster #(
  parameter int CORDW       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic io_aresetn,
  input  logic io_btn,
  output logic io_led,
  spi_quad_raster_if.slave spi
`ifdef SPI_QUAD_PIXEL_PORT_EN
  ,
  output logic             io_pix_valid,
  output logic [CORDW-1:0] io_pix_x,
  output logic [CORDW-1:0] io_pix_y
`endif
);

  localparam int W = CORDW + 2;
  typedef logic signed [W-1:0] sw_t;
  typedef enum logic [1:0] {IDLE, SETUP, STEP} state_t;

  localparam sw_t ONE  = sw_t'(1);
  localparam sw_t MONE = sw_t'(-1);

  logic [SYNC_STAGES-1:0] sclk_sr, mosi_sr, cs_sr, btn_sr;
  logic sclk_q, cs_q, btn_q;
  logic sclk_s, mosi_s, cs_s, btn_s;

  assign sclk_s = sclk_sr[SYNC_STAGES-1];
  assign mosi_s = mosi_sr[SYNC_STAGES-1];
  assign cs_s   = cs_sr[SYNC_STAGES-1];
  assign btn_s  = btn_sr[SYNC_STAGES-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      cs_sr   <= '1;
      btn_sr  <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      btn_q   <= 1'b0;
    end else if (!io_aresetn) begin
      sclk_sr <= '0;
      mosi_sr <= '0;
      cs_sr   <= '1;
      btn_sr  <= '0;
      sclk_q  <= 1'b0;
      cs_q    <= 1'b1;
      btn_q   <= 1'b0;
    end else begin
      sclk_sr <= {sclk_sr[SYNC_STAGES-2:0], spi.io_spi_sclk};
      mosi_sr <= {mosi_sr[SYNC_STAGES-2:0], spi.io_spi_mosi};
      cs_sr   <= {cs_sr[SYNC_STAGES-2:0], spi.io_spi_cs};
      btn_sr  <= {btn_sr[SYNC_STAGES-2:0], io_btn};
      sclk_q  <= sclk_s;
      cs_q    <= cs_s;
      btn_q   <= btn_s;
    end
  end

  logic sclk_rise, sclk_fall, cs_fall, btn_rise;
  assign sclk_rise = sclk_s & ~sclk_q;
  assign sclk_fall = ~sclk_s & sclk_q;
  assign cs_fall   = cs_q & ~cs_s;
  assign btn_rise  = btn_s & ~btn_q;

  logic [3:0]       bit_cnt;
  logic [2:0]       idx;
  logic [CORDW-1:0] rx_sr, tx_sr, last_word;
  logic [CORDW-1:0] wbuf [0:6];
  logic [CORDW-1:0] word_in;
  logic             word_done, frame_done;

  assign word_in    = {rx_sr[CORDW-2:0], mosi_s};
  assign word_done  = ~cs_s & sclk_rise & (bit_cnt == 4'd15);
  assign frame_done = word_done & (idx == 3'd7);

  assign spi.io_spi_miso = ~cs_s & tx_sr[CORDW-1];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      bit_cnt   <= '0;
      idx       <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      last_word <= '0;
      for (int i = 0; i < 7; i++) wbuf[i] <= '0;
    end else if (!io_aresetn) begin
      bit_cnt   <= '0;
      idx       <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      last_word <= '0;
      for (int i = 0; i < 7; i++) wbuf[i] <= '0;
    end else begin
      if (cs_fall)
        tx_sr <= last_word;
      else if (~cs_s & sclk_fall)
        tx_sr <= {tx_sr[CORDW-2:0], 1'b0};
      // cs high drops any partial frame; completed words stay
      if (cs_s) begin
        bit_cnt <= '0;
        idx     <= '0;
      end else if (sclk_rise) begin
        rx_sr   <= word_in;
        bit_cnt <= bit_cnt + 4'd1;
        if (bit_cnt == 4'd15) begin
          if (idx != 3'd7) wbuf[idx] <= word_in;
          last_word <= word_in;
          idx       <= idx + 3'd1;
        end
      end
    end
  end

  state_t           state;
  logic [1:0]       eidx, enx;
  logic [CORDW-1:0] vx [0:3];
  logic [CORDW-1:0] vy [0:3];
  logic             have_quad;
  sw_t              x, y, dx, dy, err;
  logic             sx_neg, sy_neg;

  logic [CORDW-1:0] xs, ys, xe, ye, adx, ady;
  sw_t              e2, adx_s, ady_s;
  logic             step_x, step_y, at_end, start;

  assign enx    = eidx + 2'd1;
  assign xs     = vx[eidx];
  assign ys     = vy[eidx];
  assign xe     = vx[enx];
  assign ye     = vy[enx];
  assign adx    = (xe >= xs) ? xe - xs : xs - xe;
  assign ady    = (ye >= ys) ? ye - ys : ys - ye;
  assign adx_s  = sw_t'({2'b00, adx});
  assign ady_s  = sw_t'({2'b00, ady});
  assign e2     = err <<< 1;
  assign step_x = e2 >= dy;
  assign step_y = e2 <= dx;
  assign at_end = (x == sw_t'({2'b00, xe})) && (y == sw_t'({2'b00, ye}));
  assign start  = (state == IDLE) & (frame_done | (btn_rise & have_quad));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      eidx      <= '0;
      have_quad <= 1'b0;
      io_led    <= 1'b0;
      x         <= '0;
      y         <= '0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
    end else if (!io_aresetn) begin
      state     <= IDLE;
      eidx      <= '0;
      have_quad <= 1'b0;
      io_led    <= 1'b0;
      x         <= '0;
      y         <= '0;
      dx        <= '0;
      dy        <= '0;
      err       <= '0;
      sx_neg    <= 1'b0;
      sy_neg    <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        vx[i] <= '0;
        vy[i] <= '0;
      end
    end else begin
      // a frame landing mid-draw must not disturb the edge in flight
      if (frame_done && state == IDLE) begin
        vx[0]     <= wbuf[0];
        vy[0]     <= wbuf[1];
        vx[1]     <= wbuf[2];
        vy[1]     <= wbuf[3];
        vx[2]     <= wbuf[4];
        vy[2]     <= wbuf[5];
        vx[3]     <= wbuf[6];
        vy[3]     <= word_in;
        have_quad <= 1'b1;
      end
      unique case (state)
        IDLE: begin
          if (start) begin
            state  <= SETUP;
            eidx   <= '0;
            io_led <= 1'b0;
          end
        end
        SETUP: begin
          x      <= sw_t'({2'b00, xs});
          y      <= sw_t'({2'b00, ys});
          dx     <= adx_s;
          dy     <= -ady_s;
          err    <= adx_s - ady_s;
          sx_neg <= xe < xs;
          sy_neg <= ye < ys;
          state  <= STEP;
        end
        STEP: begin
          if (at_end) begin
            if (eidx == 2'd3) begin
              state  <= IDLE;
              io_led <= 1'b1;
            end else begin
              eidx  <= enx;
              state <= SETUP;
            end
          end else begin
            err <= err + (step_x ? dy : '0) + (step_y ? dx : '0);
            if (step_x) x <= x + (sx_neg ? MONE : ONE);
            if (step_y) y <= y + (sy_neg ? MONE : ONE);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SPI_QUAD_PIXEL_PORT_EN
  assign io_pix_valid = (state == STEP);
  assign io_pix_x     = x[CORDW-1:0];
  assign io_pix_y     = y[CORDW-1:0];
`endif

endmodule

// File: tb/tb_spi_quad_raster.sv
// Directed + randomized bench for spi_quad_raster with a Bresenham reference.
// Pixel-stream checks are active when SPI_QUAD_PIXEL_PORT_EN is defined.
module tb_spi_quad_raster;

  localparam int HALF = 250;

  logic clock, reset, io_aresetn, io_btn, io_led;
  spi_quad_raster_if bus ();
`ifdef SPI_QUAD_PIXEL_PORT_EN
  logic        io_pix_valid;
  logic [15:0] io_pix_x, io_pix_y;
`endif

  spi_quad_raster #(.CORDW(16), .SYNC_STAGES(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .io_aresetn (io_aresetn),
    .io_btn     (io_btn),
    .io_led     (io_led),
    .spi        (bus.slave)
`ifdef SPI_QUAD_PIXEL_PORT_EN
    ,
    .io_pix_valid (io_pix_valid),
    .io_pix_x     (io_pix_x),
    .io_pix_y     (io_pix_y)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int failed = 0;

  logic [15:0] fr [8];
  logic [15:0] rx_w [8];
  logic [15:0] last_w;
  logic [31:0] exp_q [$];
  logic [31:0] got_q [$];
  int exp_n;

  int  done_cnt = 0;
  int  low_cnt = 0;
  int  last_low = 0;
  bit  in_low = 0;
  logic prev_led = 1'b0;

  always @(negedge clock) begin
    if (reset) begin
      in_low   = 0;
      prev_led = 1'b0;
    end else begin
      if (io_led === 1'b0 && prev_led === 1'b1) begin
        in_low  = 1;
        low_cnt = 0;
      end
      if (in_low && io_led === 1'b0) low_cnt++;
      if (io_led === 1'b1 && prev_led === 1'b0) begin
        done_cnt++;
        if (in_low) last_low = low_cnt;
        in_low = 0;
      end
      prev_led = io_led;
`ifdef SPI_QUAD_PIXEL_PORT_EN
      if (io_pix_valid === 1'b1) got_q.push_back({io_pix_x, io_pix_y});
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Plain integer Bresenham over the four edges, corners repeated
  task automatic model_quad();
    exp_q.delete();
    exp_n = 0;
    for (int e = 0; e < 4; e++) begin
      int xs, ys, xe, ye, x, y, dx, dy, sx, sy, err, e2;
      xs = int'(fr[2*e]);
      ys = int'(fr[2*e+1]);
      xe = int'(fr[(2*e+2)%8]);
      ye = int'(fr[(2*e+3)%8]);
      dx = (xe > xs) ? xe - xs : xs - xe;
      dy = -((ye > ys) ? ye - ys : ys - ye);
      sx = (xe >= xs) ? 1 : -1;
      sy = (ye >= ys) ? 1 : -1;
      exp_n += ((dx > -dy) ? dx : -dy) + 1;
      x = xs;
      y = ys;
      err = dx + dy;
      forever begin
        exp_q.push_back({x[15:0], y[15:0]});
        if (x == xe && y == ye) break;
        e2 = 2 * err;
        if (e2 >= dy) begin err += dy; x += sx; end
        if (e2 <= dx) begin err += dx; y += sy; end
      end
    end
  endtask

  task automatic spi_send(input int nbits);
    bus.io_spi_cs = 1'b0;
    #(HALF);
    for (int b = 0; b < nbits; b++) begin
      int wi, bi;
      wi = b / 16;
      bi = 15 - (b % 16);
      bus.io_spi_mosi = fr[wi][bi];
      #(HALF);
      rx_w[wi][bi] = bus.io_spi_miso;
      bus.io_spi_sclk = 1'b1;
      #(HALF);
      bus.io_spi_sclk = 1'b0;
    end
    #(HALF);
    bus.io_spi_cs = 1'b1;
    #(2*HALF);
  endtask

  task automatic wait_done(input string tag, input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 20000) begin
      @(negedge clock);
      n++;
    end
    chk({tag, "_done"}, 32'(done_cnt > d0), 1);
  endtask

  task automatic check_pix(input string tag);
`ifdef SPI_QUAD_PIXEL_PORT_EN
    int bad = 0;
    int first = -1;
    chk({tag, "_npix"}, got_q.size(), exp_n);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) begin
        bad++;
        if (first < 0) first = i;
      end
    chk({tag, "_pixseq"}, bad, 0);
    if (first >= 0)
      $display("  %s first divergence at pixel %0d: %h vs %h",
               tag, first, got_q[first], exp_q[first]);
`else
    $display("  %s: pixel port not built, timing checks only", tag);
`endif
  endtask

  task automatic draw_frame(input string tag);
    logic was_high;
    int d0;
    model_quad();
    was_high = io_led;
    d0 = done_cnt;
    got_q.delete();
    spi_send(128);
    chk({tag, "_echo"}, rx_w[0], last_w);
    last_w = fr[7];
    if (exp_n > 300) chk({tag, "_led_busy"}, io_led, 0);
    wait_done(tag, d0);
    chk({tag, "_led_done"}, io_led, 1);
    check_pix(tag);
    if (was_high) chk({tag, "_cycles"}, last_low, exp_n + 4);
  endtask

  task automatic pulse_btn();
    io_btn = 1'b1;
    repeat (6) @(negedge clock);
    io_btn = 1'b0;
    repeat (6) @(negedge clock);
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 8; i++) fr[i] = 16'($urandom_range(0, 300));
  endtask

  initial begin
    int d0, sz;
    reset = 1'b1;
    io_aresetn = 1'b1;
    io_btn = 1'b0;
    bus.io_spi_cs = 1'b1;
    bus.io_spi_sclk = 1'b0;
    bus.io_spi_mosi = 1'b0;
    last_w = '0;
    repeat (5) @(negedge clock);
    chk("rst_led", io_led, 0);
    chk("rst_miso", bus.io_spi_miso, 0);
`ifdef SPI_QUAD_PIXEL_PORT_EN
    chk("rst_pix_valid", io_pix_valid, 0);
    chk("rst_pix_xy", {io_pix_x, io_pix_y}, 0);
`endif
    reset = 1'b0;
    repeat (5) @(negedge clock);

    fr = '{16'd0, 16'd0, 16'd0, 16'd100, 16'd100, 16'd100, 16'd100, 16'd0};
    draw_frame("t1_square");
    chk("t1_npix_formula", exp_n, 404);

    d0 = done_cnt;
    got_q.delete();
    pulse_btn();
    repeat (100) @(negedge clock);
    chk("t5_led_busy", io_led, 0);
    pulse_btn();
    wait_done("t5_redraw", d0);
    check_pix("t5_redraw");
    chk("t5_cycles", last_low, 408);
    sz = got_q.size();
    repeat (500) @(negedge clock);
    chk("t5_btn_ignored", done_cnt, d0 + 1);
    chk("t5_no_extra_pix", got_q.size(), sz);

    fr = '{16'd1, 16'd0, 16'd1, 16'd100, 16'd101, 16'd100, 16'd101, 16'd0};
    draw_frame("t2_shifted");

    rand_frame();
    spi_send(40);
    chk("t3_partial_echo", rx_w[0], last_w);
    last_w = fr[1];
    fr = '{16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0};
    draw_frame("t3_degenerate");

    fr = '{16'd10, 16'd10, 16'd10, 16'd2010,
           16'd2010, 16'd2010, 16'd2010, 16'd10};
    model_quad();
    d0 = done_cnt;
    got_q.delete();
    spi_send(128);
    chk("t4_big_echo", rx_w[0], last_w);
    last_w = fr[7];
    rand_frame();
    spi_send(128);
    chk("t4_drop_echo", rx_w[0], last_w);
    last_w = fr[7];
    chk("t4_led_busy", io_led, 0);
    wait_done("t4_big", d0);
    check_pix("t4_big");
    chk("t4_cycles", last_low, 8008);
    repeat (1500) @(negedge clock);
    chk("t4_dropped_no_draw", done_cnt, d0 + 1);

    rand_frame();
    draw_frame("t4_next");

    fr = '{16'd0, 16'd0, 16'd0, 16'd100, 16'd100, 16'd100, 16'd100, 16'd0};
    d0 = done_cnt;
    spi_send(128);
    @(posedge clock);
    #1 reset = 1'b1;
    @(negedge clock);
    chk("t6_led", io_led, 0);
`ifdef SPI_QUAD_PIXEL_PORT_EN
    chk("t6_pix_valid", io_pix_valid, 0);
`endif
    repeat (3) @(negedge clock);
    reset = 1'b0;
    last_w = '0;
    got_q.delete();
    pulse_btn();
    repeat (500) @(negedge clock);
    chk("t6_btn_no_draw", done_cnt, d0);
    chk("t6_led_low", io_led, 0);
`ifdef SPI_QUAD_PIXEL_PORT_EN
    chk("t6_no_pix", got_q.size(), 0);
`endif

    rand_frame();
    draw_frame("t7_after_reset");

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
